uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receiver. Successor to the fixed 8-bit receiver that feeds the LED/7-segment path.
//   Adds configurable width, bit order, parity and stop bits, plus 3-sample majority voting.
//   Adds framing/parity/overrun detection and a valid/ready output handshake.
//   Sits between the Bluetooth module's TX pin and the display decoder.
// PARAMETERS
//   CLKS_PER_BIT  8   clk cycles per UART bit; must be >= 4
//   DATA_BITS     8   payload bits per frame, 5..9
//   MSB_FIRST     1   1: first data bit -> rx_data[DATA_BITS-1]; 0: first -> rx_data[0]
//   PARITY        0   0 none, 1 even, 2 odd
//   STOP_BITS     1   1 or 2
//   SYNC_STAGES   2   input synchroniser depth, >= 2
// PORTS
//   clk         in   1          system clock; everything on rising edge
//   reset       in   1          asynchronous, active-high reset
//   uart_rx     in   1          serial line, idle high, asynchronous to clk
//   rx_data     out  DATA_BITS  received payload, stable while rx_valid=1
//   rx_valid    out  1          payload available; held until accepted
//   rx_ready    in   1          consumer accepts on rx_valid & rx_ready
//   frame_err   out  1          last delivered frame had a 0 stop bit; qualified by rx_valid
//   parity_err  out  1          last delivered frame had a parity mismatch; qualified by rx_valid
//   overrun     out  1          sticky: a frame completed while rx_valid=1 and was dropped
//   busy        out  1          1 in any state except IDLE
// BEHAVIOUR
//   Reset values:
//     - outputs: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
//     - internal: synchroniser=all 1, state=IDLE.
//     - Reset mid-frame discards the partial frame.
//   Sampling:
//     - uart_rx passes through SYNC_STAGES flops; "rxs" is the synchronised value.
//     - Bit counter runs 0..CLKS_PER_BIT-1 and then wraps.
//     - Each bit value is the majority of rxs at counts M-1, M and M+1, where M = CLKS_PER_BIT/2.
//     - The bit is decided at count M+1.
//   FSM states: IDLE, START, DATA, PAR, STOP, BRK.
//     - IDLE -> START on rxs 1->0; counter cleared. This cycle is t0.
//     - START: voted 1 -> IDLE (glitch, no output). Voted 0 -> DATA.
//     - DATA: shift DATA_BITS bits in the order set by MSB_FIRST, then -> PAR if PARITY!=0, else -> STOP.
//     - PAR: even parity requires XOR(data, parity bit)=0; odd parity requires 1.
//     - STOP: check each stop bit; any stop bit voted 0 sets frame_err for this frame.
//     - After the last stop vote: go to IDLE if rxs=1. If rxs=0, go to BRK.
//     - BRK waits for rxs=1 before returning to IDLE; no start is detected while in BRK.
//     - FSM returns to IDLE right after the last stop vote, so back-to-back frames need no idle gap.
//   Latency:
//     - N = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
//     - rx_valid rises at cycle t0 + (N-1)*CLKS_PER_BIT + M + 2.
//     - rx_data, frame_err and parity_err update in that same cycle.
//   Handshake:
//     - Frame done with rx_valid=0: load rx_data and error flags, set rx_valid=1.
//     - rx_valid & rx_ready: clear rx_valid and overrun on the next edge.
//     - Frame done while rx_valid=1 and no accept in that cycle: new frame dropped, rx_data kept, overrun=1.
//     - Frame done in the same cycle as an accept: new frame loaded, rx_valid stays 1, no overrun.
//   Errored frames are still delivered. The consumer decides whether to discard them.
// TESTING
//   Defaults, rx_ready=1, send 0xA5 MSB-first at 8 clk/bit:
//     -> rx_data=8'hA5, rx_valid high exactly 1 cycle, all error flags 0.
//   MSB_FIRST=0, PARITY=1, send 0x3C with parity bit 1:
//     -> rx_data=8'h3C, parity_err=1. Same byte with parity bit 0 -> parity_err=0.
//   Send 0x55 with stop bit 0, then hold line low 40 cycles:
//     -> frame_err=1, no further frame while low.
//     -> line high, then send 0x12 -> rx_data=8'h12, frame_err=0.
//   Noise cases, expected response:
//     - 2-cycle low pulse on idle line -> no rx_valid, busy returns to 0 within CLKS_PER_BIT cycles.
//     - 1-cycle inverted glitch at the centre of data bit 3 of 0xF0 -> rx_data=8'hF0 (vote masks it).
//   rx_ready=0, send 0x11 then 0x22:
//     -> rx_data=8'h11, overrun=1. Raise rx_ready -> rx_valid=0, overrun=0 next cycle.
//   Assert reset during DATA of 0x77:
//     -> all outputs at reset values. Release, send 0x99 -> rx_data=8'h99, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised UART receiver with 3-sample majority voting,
//            configurable width/bit order/parity/stop bits, framing, parity
//            and overrun detection, and a valid/ready output handshake.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-high reset
//            uart_rx    - serial line, idle high, asynchronous to clk
//            rx_data    - received payload, stable while rx_valid=1
//            rx_valid   - payload available, held until accepted
//            rx_ready   - consumer accepts on rx_valid & rx_ready
//            frame_err  - delivered frame had a 0 stop bit (qualified by rx_valid)
//            parity_err - delivered frame had a parity mismatch (qualified by rx_valid)
//            overrun    - sticky: a completed frame was dropped while rx_valid=1
//            busy       - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_BW = $clog2(DATA_BITS);
    localparam int c_M  = CLKS_PER_BIT / 2;

    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_SMP0      = c_CW'(c_M - 1);
    localparam logic [c_CW-1:0] c_SMP1      = c_CW'(c_M);
    localparam logic [c_CW-1:0] c_DECIDE    = c_CW'(c_M + 1);
    localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DATA_BITS - 1);
    localparam logic            c_STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;
    localparam logic [2:0] c_BRK   = 3'd5;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_prev;
    logic [2:0]             r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_BW-1:0]        r_bit_idx;
    logic                   r_stop_idx;
    logic                   r_s0;
    logic                   r_s1;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_ferr;
    logic                   r_perr;

    logic                   w_rxs;
    logic                   w_vote;
    logic                   w_decide;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   w_par_xor;
    logic                   w_par_bad;
    logic                   w_done;
    logic                   w_frame_err;
    logic                   w_accept;

    // Synchroniser resets to all ones so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign w_rxs    = r_sync[SYNC_STAGES-1];
    // Two samples are stored; the third is the live value at the decision count.
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_decide = (r_cnt == c_DECIDE);

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_next = {r_shift[DATA_BITS-2:0], w_vote};
        end else begin : g_lsb_first
            assign w_shift_next = {w_vote, r_shift[DATA_BITS-1:1]};
        end
    endgenerate

    // r_shift already holds the complete payload when the parity bit is voted.
    assign w_par_xor   = (^r_shift) ^ w_vote;
    assign w_par_bad   = (PARITY == 2) ? ~w_par_xor : w_par_xor;
    assign w_done      = (r_state == c_STOP) && w_decide && (r_stop_idx == c_STOP_LAST);
    assign w_frame_err = r_ferr | ~w_vote;
    assign w_accept    = rx_valid & rx_ready;
    assign busy        = (r_state != c_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_rxs_prev <= 1'b1;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_rxs_prev <= w_rxs;

            // Counter idles at zero so the first START cycle is count 0.
            if (r_state == c_IDLE || r_state == c_BRK || r_cnt == c_CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end

            if (r_cnt == c_SMP0) begin
                r_s0 <= w_rxs;
            end
            if (r_cnt == c_SMP1) begin
                r_s1 <= w_rxs;
            end

            case (r_state)
                c_IDLE: begin
                    if (r_rxs_prev && !w_rxs) begin
                        r_state    <= c_START;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_perr     <= 1'b0;
                    end
                end
                c_START: begin
                    if (w_decide) begin
                        r_state <= w_vote ? c_IDLE : c_DATA;
                    end
                end
                c_DATA: begin
                    if (w_decide) begin
                        r_shift <= w_shift_next;
                        if (r_bit_idx == c_BIT_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != 0) ? c_PAR : c_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_BW'(1);
                        end
                    end
                end
                c_PAR: begin
                    if (w_decide) begin
                        r_perr  <= w_par_bad;
                        r_state <= c_STOP;
                    end
                end
                c_STOP: begin
                    if (w_decide) begin
                        if (!w_vote) begin
                            r_ferr <= 1'b1;
                        end
                        if (r_stop_idx == c_STOP_LAST) begin
                            // A line still low here is a break; wait for it to end.
                            r_state <= w_rxs ? c_IDLE : c_BRK;
                        end else begin
                            r_stop_idx <= r_stop_idx + 1'b1;
                        end
                    end
                end
                c_BRK: begin
                    if (w_rxs) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Output register: a finished frame is loaded if the holding slot is free
    // or is being emptied in this same cycle; otherwise it is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (w_done && (!rx_valid || rx_ready)) begin
                rx_data    <= r_shift;
                frame_err  <= w_frame_err;
                parity_err <= r_perr;
                rx_valid   <= 1'b1;
            end else if (w_accept) begin
                rx_valid <= 1'b0;
            end

            if (w_accept) begin
                overrun <= 1'b0;
            end else if (w_done && rx_valid) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
